// File: rtl/s2mm_burst_writer.sv
// s2mm_burst_writer: buffers a 32-bit AXI4-Stream in a small FIFO and writes
// it to memory as a sequence of AXI4 INCR bursts (one burst outstanding).
// Control and status connect to the AXI-Lite register block.
module s2mm_burst_writer #(
  parameter int C_DATA_WIDTH = 32,
  parameter int C_ADDR_WIDTH = 32,
  parameter int C_BURST_LEN  = 8,
  parameter int C_FIFO_DEPTH = 16,
  parameter int C_LEN_WIDTH  = 16
) (
  input  logic                    ACLK,
  input  logic                    ARESET,
  // control / status
  input  logic                    cfg_start,
  input  logic [C_ADDR_WIDTH-1:0] cfg_addr,
  input  logic [C_LEN_WIDTH-1:0]  cfg_len,
  output logic                    sts_busy,
  output logic                    sts_done,
  output logic                    sts_error,
  // input stream
  input  logic [C_DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  // AXI4 write address channel
  output logic [C_ADDR_WIDTH-1:0] m_axi_awaddr,
  output logic [7:0]              m_axi_awlen,
  output logic [2:0]              m_axi_awsize,
  output logic [1:0]              m_axi_awburst,
  output logic                    m_axi_awvalid,
  input  logic                    m_axi_awready,
  // AXI4 write data channel
  output logic [C_DATA_WIDTH-1:0] m_axi_wdata,
  output logic [3:0]              m_axi_wstrb,
  output logic                    m_axi_wlast,
  output logic                    m_axi_wvalid,
  input  logic                    m_axi_wready,
  // AXI4 write response channel
  input  logic [1:0]              m_axi_bresp,
  input  logic                    m_axi_bvalid,
  output logic                    m_axi_bready
);

  localparam int PTR_W = $clog2(C_FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0]       FIFO_FULL = CNT_W'(C_FIFO_DEPTH);
  localparam logic [C_LEN_WIDTH-1:0] BURST_MAX = C_LEN_WIDTH'(C_BURST_LEN);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_RESP,
    S_DONE
  } state_t;

  state_t state_q, state_d;
  logic   awvalid_q, awvalid_d;

  logic [C_ADDR_WIDTH-1:0] addr_q;
  logic [C_LEN_WIDTH-1:0]  words_left_q;
  logic [C_LEN_WIDTH-1:0]  beats_left_q;
  logic [7:0]              beat_cnt_q;
  logic                    error_q;

  logic [C_DATA_WIDTH-1:0] fifo_mem [C_FIFO_DEPTH];
  logic [PTR_W-1:0]        wr_ptr_q;
  logic [PTR_W-1:0]        rd_ptr_q;
  logic [CNT_W-1:0]        count_q;

  logic [C_LEN_WIDTH-1:0]  burst;
  logic [7:0]              burst_m1;
  logic                    fifo_has_burst;
  logic                    start_accept;
  logic                    push;
  logic                    pop;
  logic                    wlast_int;
  logic                    b_hs;

  // Current burst is the full burst size unless fewer beats remain.
  assign burst          = (beats_left_q > BURST_MAX) ? BURST_MAX : beats_left_q;
  assign burst_m1       = 8'(burst - C_LEN_WIDTH'(1));
  assign fifo_has_burst = (32'(count_q) >= 32'(burst));

  assign start_accept = (state_q == S_IDLE) && cfg_start;
  assign push         = s_axis_tvalid && s_axis_tready;
  assign pop          = m_axi_wvalid && m_axi_wready;
  assign wlast_int    = (state_q == S_DATA) && (beat_cnt_q == burst_m1);
  assign b_hs         = m_axi_bready && m_axi_bvalid;

  // Stream side only takes words that belong to the current transfer.
  assign s_axis_tready = sts_busy && (count_q != FIFO_FULL) && (words_left_q != '0);

  assign m_axi_awvalid = awvalid_q;
  assign m_axi_awaddr  = addr_q;
  assign m_axi_awlen   = awvalid_q ? burst_m1 : 8'd0;
  assign m_axi_awsize  = 3'b010;
  assign m_axi_awburst = 2'b01;
  assign m_axi_wstrb   = 4'hF;
  assign m_axi_wlast   = wlast_int;
  assign m_axi_wdata   = (state_q == S_DATA) ? fifo_mem[rd_ptr_q] : '0;
  assign sts_error     = error_q;

  // State register plus the registered AW valid.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q   <= S_IDLE;
      awvalid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      awvalid_q <= awvalid_d;
    end
  end

  // Next-state and channel handshake outputs.
  always_comb begin
    state_d      = state_q;
    awvalid_d    = awvalid_q;
    sts_busy     = 1'b0;
    sts_done     = 1'b0;
    m_axi_wvalid = 1'b0;
    m_axi_bready = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cfg_start) begin
          state_d = (cfg_len == '0) ? S_DONE : S_ADDR;
        end
      end
      S_ADDR: begin
        sts_busy = 1'b1;
        // AW is only offered once the whole burst is buffered, so W never
        // stalls mid-burst; once offered the fields are frozen until accepted.
        if (awvalid_q) begin
          if (m_axi_awready) begin
            awvalid_d = 1'b0;
            state_d   = S_DATA;
          end
        end else if (fifo_has_burst) begin
          awvalid_d = 1'b1;
        end
      end
      S_DATA: begin
        sts_busy     = 1'b1;
        m_axi_wvalid = 1'b1;
        if (m_axi_wready && wlast_int) begin
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        sts_busy     = 1'b1;
        m_axi_bready = 1'b1;
        if (m_axi_bvalid) begin
          state_d = (beats_left_q == burst) ? S_DONE : S_ADDR;
        end
      end
      S_DONE: begin
        sts_done = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Transfer bookkeeping: address, remaining words/beats and in-burst beat count.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      addr_q       <= '0;
      words_left_q <= '0;
      beats_left_q <= '0;
      beat_cnt_q   <= '0;
    end else if (start_accept) begin
      addr_q       <= cfg_addr;
      words_left_q <= cfg_len;
      beats_left_q <= cfg_len;
      beat_cnt_q   <= '0;
    end else begin
      if (push) begin
        words_left_q <= words_left_q - C_LEN_WIDTH'(1);
      end
      if (pop) begin
        beat_cnt_q <= wlast_int ? 8'd0 : beat_cnt_q + 8'd1;
      end
      if (b_hs) begin
        addr_q       <= addr_q + C_ADDR_WIDTH'({burst, 2'b00});
        beats_left_q <= beats_left_q - burst;
      end
    end
  end

  // Sticky error: any non-OKAY response sets it, a new accepted start clears it.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      error_q <= 1'b0;
    end else if (start_accept) begin
      error_q <= 1'b0;
    end else if (b_hs && (m_axi_bresp != 2'b00)) begin
      error_q <= 1'b1;
    end
  end

  // FIFO storage; the read side is first-word-fall-through.
  always_ff @(posedge ACLK) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= s_axis_tdata;
    end
  end

  // FIFO pointers wrap naturally; occupancy holds on simultaneous push and pop.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_s2mm_burst_writer.sv
// tb_s2mm_burst_writer: drives random stream traffic and a randomly stalling
// AXI slave, and compares every AW/W beat and the status against a
// transfer-level model of how a length splits into bursts.
module tb_s2mm_burst_writer;

  localparam int BL = 8;
  localparam int FD = 16;

  logic        clk = 1'b0;
  logic        ARESET = 1'b1;
  logic        cfg_start = 1'b0;
  logic [31:0] cfg_addr = '0;
  logic [15:0] cfg_len = '0;
  logic        sts_busy, sts_done, sts_error;
  logic [31:0] s_axis_tdata = '0;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tready;
  logic [31:0] m_axi_awaddr;
  logic [7:0]  m_axi_awlen;
  logic [2:0]  m_axi_awsize;
  logic [1:0]  m_axi_awburst;
  logic        m_axi_awvalid;
  logic        m_axi_awready = 1'b0;
  logic [31:0] m_axi_wdata;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_wlast;
  logic        m_axi_wvalid;
  logic        m_axi_wready = 1'b0;
  logic [1:0]  m_axi_bresp = 2'b00;
  logic        m_axi_bvalid = 1'b0;
  logic        m_axi_bready;

  always #5 clk = ~clk;

  s2mm_burst_writer dut (
    .ACLK          (clk),
    .ARESET        (ARESET),
    .cfg_start     (cfg_start),
    .cfg_addr      (cfg_addr),
    .cfg_len       (cfg_len),
    .sts_busy      (sts_busy),
    .sts_done      (sts_done),
    .sts_error     (sts_error),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .m_axi_awaddr  (m_axi_awaddr),
    .m_axi_awlen   (m_axi_awlen),
    .m_axi_awsize  (m_axi_awsize),
    .m_axi_awburst (m_axi_awburst),
    .m_axi_awvalid (m_axi_awvalid),
    .m_axi_awready (m_axi_awready),
    .m_axi_wdata   (m_axi_wdata),
    .m_axi_wstrb   (m_axi_wstrb),
    .m_axi_wlast   (m_axi_wlast),
    .m_axi_wvalid  (m_axi_wvalid),
    .m_axi_wready  (m_axi_wready),
    .m_axi_bresp   (m_axi_bresp),
    .m_axi_bvalid  (m_axi_bvalid),
    .m_axi_bready  (m_axi_bready)
  );

  int n_vectors = 0;
  int n_miscompares = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vectors++;
    if (got !== exp) begin
      n_miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // model / scoreboard state
  logic [31:0] stream_q[$];
  logic [31:0] exp_aw_addr_q[$];
  logic [7:0]  exp_aw_len_q[$];
  logic [31:0] exp_w_data_q[$];
  logic        exp_w_last_q[$];
  logic [1:0]  bresp_plan_q[$];
  int          occ = 0, accepted = 0, cur_len = 0, done_cnt = 0, b_pending = 0;
  int          smode = 0, bpmode = 0, tick = 0;
  bit          mon_en = 1'b0, xfer_active = 1'b0, exp_err = 1'b0;
  bit          t_hs_prev, b_hs_prev, prev_aw_wait, prev_w_wait, prev_awvalid, in_burst;
  logic [31:0] prev_awaddr, prev_wdata;
  logic [7:0]  prev_awlen;
  logic        prev_wlast;

  // Slave and stream drivers plus per-cycle protocol monitor.
  always @(negedge clk) begin
    if (sts_done) begin
      done_cnt++;
      check("busy_at_done", 64'(sts_busy), 64'(0));
    end
    if (!mon_en) begin
      s_axis_tvalid = 1'b0;
      s_axis_tdata  = '0;
      m_axi_awready = 1'b0;
      m_axi_wready  = 1'b0;
      m_axi_bvalid  = 1'b0;
      m_axi_bresp   = 2'b00;
      t_hs_prev = 0; b_hs_prev = 0; prev_aw_wait = 0; prev_w_wait = 0;
      prev_awvalid = 0; in_burst = 0;
    end else begin
      tick++;
      if (prev_aw_wait) begin
        check("aw_hold_valid", 64'(m_axi_awvalid), 64'(1));
        check("aw_hold_addr", 64'(m_axi_awaddr), 64'(prev_awaddr));
        check("aw_hold_len", 64'(m_axi_awlen), 64'(prev_awlen));
      end
      if (prev_w_wait) begin
        check("w_hold_valid", 64'(m_axi_wvalid), 64'(1));
        check("w_hold_data", 64'(m_axi_wdata), 64'(prev_wdata));
        check("w_hold_last", 64'(m_axi_wlast), 64'(prev_wlast));
      end
      if (in_burst) check("wvalid_gap", 64'(m_axi_wvalid), 64'(1));
      if (m_axi_awvalid && !prev_awvalid) begin
        check("aw_expected", 64'(exp_aw_addr_q.size() != 0), 64'(1));
        if (exp_aw_addr_q.size() != 0)
          check("aw_early", 64'(occ >= int'(exp_aw_len_q[0]) + 1), 64'(1));
      end
      prev_awvalid = m_axi_awvalid;

      m_axi_awready = (bpmode == 0) ? 1'b1 : ($urandom_range(0, 2) != 0);
      m_axi_wready  = (bpmode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);

      // write response channel (decided before this cycle's W beat)
      if (!(m_axi_bvalid && !b_hs_prev)) begin
        if (b_pending > 0 && (bpmode == 0 || $urandom_range(0, 1) == 1)) begin
          m_axi_bvalid = 1'b1;
          m_axi_bresp  = 2'b00;
          if (bresp_plan_q.size() != 0) m_axi_bresp = bresp_plan_q.pop_front();
          b_pending--;
        end else begin
          m_axi_bvalid = 1'b0;
          m_axi_bresp  = 2'b00;
        end
      end
      b_hs_prev = m_axi_bvalid && m_axi_bready;

      // address channel
      prev_aw_wait = m_axi_awvalid && !m_axi_awready;
      prev_awaddr  = m_axi_awaddr;
      prev_awlen   = m_axi_awlen;
      if (m_axi_awvalid && m_axi_awready) begin
        if (exp_aw_addr_q.size() == 0) begin
          check("aw_extra", 64'(1), 64'(0));
        end else begin
          check("aw_addr", 64'(m_axi_awaddr), 64'(exp_aw_addr_q.pop_front()));
          check("aw_len", 64'(m_axi_awlen), 64'(exp_aw_len_q.pop_front()));
          check("aw_size_burst", 64'({m_axi_awsize, m_axi_awburst}), 64'({3'b010, 2'b01}));
        end
        in_burst = 1'b1;
      end

      // data channel
      prev_w_wait = m_axi_wvalid && !m_axi_wready;
      prev_wdata  = m_axi_wdata;
      prev_wlast  = m_axi_wlast;
      if (m_axi_wvalid && m_axi_wready) begin
        check("aw_w_overlap", 64'(m_axi_awvalid), 64'(0));
        check("w_after_aw", 64'(in_burst), 64'(1));
        if (exp_w_data_q.size() == 0) begin
          check("w_extra", 64'(1), 64'(0));
        end else begin
          check("w_data", 64'(m_axi_wdata), 64'(exp_w_data_q.pop_front()));
          check("w_last", 64'(m_axi_wlast), 64'(exp_w_last_q.pop_front()));
          check("w_strb", 64'(m_axi_wstrb), 64'(4'hF));
        end
        occ--;
        if (m_axi_wlast) begin
          in_burst = 1'b0;
          b_pending++;
        end
      end

      // stream source
      if (stream_q.size() != 0 &&
          ((s_axis_tvalid && !t_hs_prev) || smode == 0 ||
           (smode == 1 && (tick % 4) == 0) ||
           (smode == 2 && $urandom_range(0, 1) == 1))) begin
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = stream_q[0];
      end else begin
        s_axis_tvalid = 1'b0;
      end
      if (xfer_active && accepted >= cur_len && s_axis_tvalid)
        check("tready_beyond_len", 64'(s_axis_tready), 64'(0));
      t_hs_prev = s_axis_tvalid && s_axis_tready;
      if (t_hs_prev) begin
        void'(stream_q.pop_front());
        occ++;
        accepted++;
        check("fifo_occ", 64'(occ <= FD), 64'(1));
      end
    end
  end

  // Build the expected bursts for a transfer and issue the start pulse.
  task automatic start_xfer(input logic [31:0] addr, input int len, input int sm,
                            input int bp, input int err_burst, input bit counting);
    logic [31:0] words[$];
    int          n;
    smode = sm; bpmode = bp; cur_len = len; accepted = 0; done_cnt = 0;
    exp_err = 1'b0;
    stream_q.delete();
    for (int i = 0; i < len + 2; i++) begin
      logic [31:0] w;
      w = counting ? 32'(i + 1) : $urandom;
      stream_q.push_back(w);
      if (i < len) words.push_back(w);
    end
    for (int b = 0; b * BL < len; b++) begin
      n = (len - b * BL > BL) ? BL : len - b * BL;
      exp_aw_addr_q.push_back(addr + 32'(b * BL * 4));
      exp_aw_len_q.push_back(8'(n - 1));
      for (int j = 0; j < n; j++) begin
        exp_w_data_q.push_back(words[b * BL + j]);
        exp_w_last_q.push_back(j == n - 1);
      end
      bresp_plan_q.push_back((b == err_burst) ? 2'b10 : 2'b00);
      if (b == err_burst) exp_err = 1'b1;
    end
    xfer_active = 1'b1;
    @(negedge clk);
    cfg_start = 1'b1; cfg_addr = addr; cfg_len = 16'(len);
    @(negedge clk);
    cfg_start = 1'b0;
    if (len == 0) begin
      check("len0_done", 64'(sts_done), 64'(1));
      check("len0_busy", 64'(sts_busy), 64'(0));
    end else begin
      check("start_busy", 64'(sts_busy), 64'(1));
    end
    check("start_err_clr", 64'(sts_error), 64'(0));
  endtask

  // Wait for completion and compare the end-of-transfer state.
  task automatic finish_xfer();
    for (int i = 0; i < 5000 && done_cnt == 0; i++) @(negedge clk);
    check("done_seen", 64'(done_cnt > 0), 64'(1));
    repeat (3) @(negedge clk);
    check("done_once", 64'(done_cnt), 64'(1));
    check("error", 64'(sts_error), 64'(exp_err));
    check("aw_left", 64'(exp_aw_addr_q.size()), 64'(0));
    check("w_left", 64'(exp_w_data_q.size()), 64'(0));
    check("accepted", 64'(accepted), 64'(cur_len));
    check("extra_left", 64'(stream_q.size()), 64'(2));
    check("busy_idle", 64'(sts_busy), 64'(0));
    if (exp_err) begin
      repeat (5) @(negedge clk);
      check("err_sticky", 64'(sts_error), 64'(1));
    end
    xfer_active = 1'b0;
    stream_q.delete();
    bresp_plan_q.delete();
    $display("xfer len=%0d addr=%08h done, error=%0b, vectors=%0d", cur_len, cfg_addr, sts_error, n_vectors);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_ctrl", 64'({m_axi_awvalid, m_axi_wvalid, m_axi_bready, sts_busy,
                           sts_done, sts_error, s_axis_tready, m_axi_wlast}), 64'(0));
    check("rst_awaddr", 64'(m_axi_awaddr), 64'(0));
    check("rst_awlen", 64'(m_axi_awlen), 64'(0));
    check("rst_wdata", 64'(m_axi_wdata), 64'(0));
    ARESET = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);

    start_xfer(32'h1000, 16, 0, 0, -1, 1'b1); finish_xfer();
    start_xfer(32'h2000, 11, 0, 0, -1, 1'b0); finish_xfer();
    start_xfer(32'h3000, 8, 1, 0, -1, 1'b0);  finish_xfer();
    start_xfer(32'h4000, 32, 2, 1, -1, 1'b0); finish_xfer();
    start_xfer(32'h5000, 24, 2, 1, 1, 1'b0);  finish_xfer();
    start_xfer(32'h6000, 8, 0, 1, -1, 1'b0);  finish_xfer();
    start_xfer(32'h6100, 0, 0, 0, -1, 1'b0);  finish_xfer();

    // reset in the middle of the data phase
    start_xfer(32'h7000, 32, 0, 0, -1, 1'b0);
    for (int i = 0; i < 200 && !m_axi_wvalid; i++) @(negedge clk);
    check("reach_data", 64'(m_axi_wvalid), 64'(1));
    mon_en = 1'b0;
    done_cnt = 0;
    ARESET = 1'b1;
    @(negedge clk);
    ARESET = 1'b0;
    check("rst_mid", 64'({m_axi_wvalid, m_axi_awvalid, sts_busy, s_axis_tready, sts_done}), 64'(0));
    xfer_active = 1'b0;
    stream_q.delete(); exp_aw_addr_q.delete(); exp_aw_len_q.delete();
    exp_w_data_q.delete(); exp_w_last_q.delete(); bresp_plan_q.delete();
    occ = 0; accepted = 0; b_pending = 0;
    repeat (4) @(negedge clk);
    check("rst_no_done", 64'(done_cnt), 64'(0));
    mon_en = 1'b1;
    $display("reset mid-transfer applied, vectors=%0d", n_vectors);

    // randomized transfers after reset (stale FIFO data would show as w_data errors)
    for (int k = 0; k < 5; k++) begin
      logic [31:0] a;
      a = $urandom_range(0, 32'h0FFF_FFFF) & 32'hFFFF_FFE0;
      start_xfer(a, $urandom_range(1, 40), $urandom_range(0, 2), $urandom_range(0, 1),
                 $urandom_range(0, 6), 1'b0);
      finish_xfer();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule

// File: doc/s2mm_burst_writer.md
Name: s2mm_burst_writer

Overview:
- S2MM front end of the User DMA. Accepts a 32-bit AXI4-Stream and buffers it in an internal FIFO.
- Drives the AXI4 full-master write channels (AW/W/B) with INCR bursts of up to C_BURST_LEN beats.
- Control (start, address, word count) comes from the AXI-Lite register slave; status (busy/done/error) returns to it.

Parameters:
- C_DATA_WIDTH, 32, stream and AXI data width (only 32 supported)
- C_ADDR_WIDTH, 32, AXI address width
- C_BURST_LEN, 8, maximum beats per burst (power of two, 2..16)
- C_FIFO_DEPTH, 16, input buffer depth in words (power of two, >= C_BURST_LEN)
- C_LEN_WIDTH, 16, width of the word-count field

Ports:
- ACLK  in  1  clock
- ARESET  in  1  synchronous active-high reset
- cfg_start  in  1  one-cycle start pulse; ignored while busy
- cfg_addr  in  C_ADDR_WIDTH  byte start address; must be C_BURST_LEN*4-byte aligned
- cfg_len  in  C_LEN_WIDTH  transfer length in 32-bit words; 0 means no transfer
- sts_busy  out  1  transfer in progress
- sts_done  out  1  one-cycle pulse at end of transfer
- sts_error  out  1  sticky; set on any non-OKAY BRESP, cleared by next accepted cfg_start
- s_axis_tdata  in  32  stream data
- s_axis_tvalid  in  1  stream valid
- s_axis_tready  out  1  stream ready
- m_axi_awaddr  out  C_ADDR_WIDTH  burst address
- m_axi_awlen  out  8  beats-1
- m_axi_awsize  out  3  constant 3'b010
- m_axi_awburst  out  2  constant 2'b01 (INCR)
- m_axi_awvalid  out  1
- m_axi_awready  in  1
- m_axi_wdata  out  32
- m_axi_wstrb  out  4  constant 4'hF
- m_axi_wlast  out  1
- m_axi_wvalid  out  1
- m_axi_wready  in  1
- m_axi_bresp  in  2
- m_axi_bvalid  in  1
- m_axi_bready  out  1

Behaviour:
- Reset: all outputs 0; FIFO emptied; FSM to IDLE; sticky error cleared. Reset mid-transfer abandons the transfer immediately; no done pulse.
- Start: on cfg_start in IDLE:
  - latch cfg_addr to addr_reg and cfg_len to words_left (stream side) and beats_left (AXI side);
  - clear sts_error; sts_busy=1 next cycle.
  - If cfg_len=0: go to DONE directly; no AXI traffic.
- Stream intake:
  - s_axis_tready = busy AND FIFO not full AND words_left != 0.
  - Each handshake pushes one word and decrements words_left.
  - Data beyond cfg_len is not accepted (tready stays low). tlast is not used.
- FSM: IDLE -> ADDR -> DATA -> RESP -> (ADDR | DONE) -> IDLE.
  - ADDR:
    - burst = min(C_BURST_LEN, beats_left).
    - Assert awvalid only once FIFO occupancy >= burst, so W never stalls mid-burst for lack of data.
    - awaddr=addr_reg, awlen=burst-1.
    - Hold awvalid and all AW fields stable until awready; then go to DATA.
  - DATA:
    - wvalid = 1; wdata = FIFO head (first-word-fall-through).
    - Pop on wvalid&wready.
    - wlast is high on the beat where the in-burst counter equals burst-1.
    - After the wlast handshake go to RESP.
  - RESP:
    - bready = 1.
    - On bvalid: if bresp != 2'b00, set sts_error.
    - Then addr_reg += burst*4 and beats_left -= burst.
    - beats_left == 0 -> DONE, else -> ADDR.
    - Errors do not abort; the remaining bursts still issue.
  - DONE: sts_done=1 for exactly one cycle, sts_busy=0 the same cycle, then IDLE.
- Only one outstanding burst; AW and W never overlap.
- FIFO:
  - Simultaneous push and pop at full or empty is handled correctly; occupancy is unchanged.
  - Pointers wrap modulo C_FIFO_DEPTH; occupancy counter is log2(C_FIFO_DEPTH)+1 bits.
- Latency: the first awvalid rises 1 cycle after the FIFO occupancy reaches the first burst size.
- Aligned start plus burst <= 16 beats guarantees no 4 KB boundary crossing; no split logic is required.

Test Plan:
- Len 16, addr 0x1000, stream 1..16 back-to-back, awready/wready/bvalid immediate -> two bursts: awaddr 0x1000/0x1020, awlen 7; wdata 1..16 in order; wlast on beats 8 and 16; one sts_done; sts_error=0.
- Len 11, addr 0x2000 -> bursts awlen 7 then awlen 2 at 0x2020; wlast on beat 3 of the second burst; tready low after the 11th word.
- Stream trickles one word every 4 cycles, len 8 -> awvalid stays low until the 8th word is in the FIFO; wvalid never drops mid-burst.
- Random wready/awready backpressure, len 32 -> AW and W fields stable while valid && !ready; FIFO never overflows; data matches the stream order.
- Second burst returns bresp=2'b10, len 24 -> sts_error=1 and sticky; third burst still issued; done pulses; next cfg_start clears error.
- cfg_len=0 -> sts_done one cycle after start; no awvalid. ARESET asserted mid-DATA -> wvalid/awvalid/busy 0 next cycle; FIFO empty.
